// File: rtl/seq_alu_pkg.sv
// Shared types for seq_alu: opcodes, FSM state encoding, default width.
// No logic beyond a small opcode-classification helper.
// Backpressure: n/a.
package seq_alu_pkg;

  localparam int SEQ_ALU_W = 6;

  typedef enum logic [2:0] {
    OP_XANDOR = 3'd0,
    OP_SHR    = 3'd1,
    OP_SHL    = 3'd2,
    OP_ADD    = 3'd3,
    OP_SUB    = 3'd4,
    OP_AND    = 3'd5,
    OP_OR     = 3'd6,
    OP_XOR    = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  function automatic logic is_shift(input logic [2:0] op);
    return (op == OP_SHR) || (op == OP_SHL);
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational result and carry/borrow for all non-shift opcodes.
// Latency: 0 (pure combinational).
// Backpressure: none; the caller registers the outputs.
module alu_core
  import seq_alu_pkg::*;
#(
  parameter int W = SEQ_ALU_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [2:0]   op,
  output logic [W-1:0] r,
  output logic         cf
);

  logic [W:0] sum;
  logic [W:0] diff;

  // The extra top bit is carry-out for add and borrow (a < b) for subtract.
  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    r  = '0;
    cf = 1'b0;
    case (op)
      OP_XANDOR: r = (a ^ b) & (a | b);
      OP_ADD:    {cf, r} = sum;
      OP_SUB:    {cf, r} = diff;
      OP_AND:    r = a & b;
      OP_OR:     r = a | b;
      OP_XOR:    r = a ^ b;
      default:   r = '0;
    endcase
  end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: one-cycle logic/arith ops, bit-serial shifts (one bit per cycle).
// Latency: 1 cycle for non-shift ops, shamt+1 cycles for SHR/SHL.
// Backpressure: result held in DONE until out_ready; no new op accepted until IDLE.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter  int W  = SEQ_ALU_W,
  localparam int SW = $clog2(W)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic [2:0]   OP,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] R,
  output logic         CF,
  output logic         SF,
  output logic         ZF,
  output logic         busy
);

  localparam logic [1:0] IDLE  = ST_IDLE;
  localparam logic [1:0] SHIFT = ST_SHIFT;
  localparam logic [1:0] DONE  = ST_DONE;

  logic [1:0]    state;
  logic [W-1:0]  r_q;
  logic          cf_q;
  logic [SW-1:0] cnt_q;
  logic          shl_q;
  logic          live_q;
  logic [W-1:0]  core_r;
  logic          core_cf;
  logic [SW-1:0] shamt;
  logic          accept;

  alu_core #(.W(W)) u_core (
    .a  (A),
    .b  (B),
    .op (OP),
    .r  (core_r),
    .cf (core_cf)
  );

  assign shamt  = B[SW-1:0];
  // live_q keeps in_ready low through reset and until the first edge after release.
  assign in_ready  = live_q && (state == IDLE);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign R  = r_q;
  assign CF = cf_q;
  assign SF = r_q[W-1];
  assign ZF = (r_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      r_q    <= '0;
      cf_q   <= 1'b0;
      cnt_q  <= '0;
      shl_q  <= 1'b0;
      live_q <= 1'b0;
    end else begin
      live_q <= 1'b1;
      case (state)
        IDLE: begin
          if (accept) begin
            if (is_shift(OP)) begin
              r_q   <= A;
              cf_q  <= 1'b0;
              cnt_q <= shamt;
              shl_q <= (OP == OP_SHL);
              // A zero shift amount skips SHIFT entirely to keep latency at 1.
              state <= (shamt == '0) ? DONE : SHIFT;
            end else begin
              r_q   <= core_r;
              cf_q  <= core_cf;
              state <= DONE;
            end
          end
        end
        SHIFT: begin
          if (shl_q) begin
            {cf_q, r_q} <= {r_q, 1'b0};
          end else begin
            {r_q, cf_q} <= {1'b0, r_q};
          end
          cnt_q <= cnt_q - SW'(1);
          if (cnt_q == SW'(1)) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter W, default 6, SHALL set the data width of A, B and R.
REQ-002 Parameter SW, default $clog2(W), SHALL set the shift-amount width taken from B[SW-1:0]; it is derived and not overridden.
REQ-003 Port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 Port in_valid, input, 1: operands and OP are valid.
REQ-006 Port in_ready, output, 1: the block can accept an operation.
REQ-007 Port A, input, W: operand A.
REQ-008 Port B, input, W: operand B, or the shift amount in B[SW-1:0].
REQ-009 Port OP, input, 3: opcode (0 XANDOR, 1 SHR, 2 SHL, 3 ADD, 4 SUB, 5 AND, 6 OR, 7 XOR).
REQ-010 Port out_valid, output, 1: R and the flags are valid.
REQ-011 Port out_ready, input, 1: the consumer accepts the result.
REQ-012 Port R, output, W: registered result.
REQ-013 Port CF, output, 1: carry/borrow flag, or the last bit shifted out.
REQ-014 Port SF, output, 1: sign flag, equal to R[W-1].
REQ-015 Port ZF, output, 1: zero flag, equal to (R == 0).
REQ-016 Port busy, output, 1: high in every state other than IDLE.

Function
REQ-017 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-018 in_ready SHALL be high only in IDLE; an operation is accepted when in_valid and in_ready are both high on a clock edge.
REQ-019 On acceptance of a non-shift opcode: compute R and flags, go to DONE; out_valid rises the next cycle (latency 1).
REQ-020 XANDOR SHALL give R=(A^B)&(A|B) with CF=0.
REQ-021 AND, OR and XOR SHALL be bitwise with CF=0.
REQ-022 ADD SHALL give R=(A+B) mod 2^W, with CF = carry out of bit W-1.
REQ-023 SUB SHALL give R=(A-B) mod 2^W, with CF=1 iff A<B unsigned (borrow).
REQ-024 On acceptance of SHR/SHL with shamt=B[SW-1:0]: latch A, latch shamt into a down-counter, clear CF, and go to SHIFT.
REQ-025 SHIFT SHALL shift one bit per cycle, zero-filled, with CF = the bit shifted out, decrementing the counter each cycle.
REQ-026 When the counter reaches 0, the FSM SHALL go to DONE; out_valid therefore asserts shamt+1 cycles after acceptance.
REQ-027 shamt=0 SHALL pass through SHIFT for zero shift cycles: R=A, CF=0, latency 1.
REQ-028 shamt>=W SHALL shift the full count, giving R=0 and CF=0 when shamt>W (CF = A[W-1] for SHR, A[0] for SHL when shamt==W).
REQ-029 SF and ZF SHALL always be derived from the final R and be valid together with out_valid.
REQ-030 In DONE, out_valid=1; R and the flags SHALL remain stable until out_valid and out_ready are both high, after which the FSM returns to IDLE (out_valid low the next cycle).
REQ-031 in_valid asserted outside IDLE SHALL be ignored; the inputs are not sampled.
REQ-032 OP, A and B changing after acceptance SHALL NOT affect the result in flight.

Reset
REQ-033 While rst_n=0, regardless of clk: FSM=IDLE, R=0, CF=0, counter=0, out_valid=0, busy=0.
REQ-034 During reset, in_ready SHALL be 0; it goes to 1 on the first clock edge after rst_n rises.
REQ-035 ZF=1 and SF=0 SHALL hold during reset as a consequence of R=0.
REQ-036 Reset asserted mid-SHIFT or mid-DONE SHALL abort the operation with no out_valid pulse.

Structure
REQ-037 Shared package seq_alu_pkg SHALL hold the opcode enum (3-bit), the state enum and the default width constant 6.
REQ-038 A single combinational sub-module, alu_core, SHALL compute the non-shift opcodes and their CF; shift sequencing and the FSM stay in seq_alu.

Verification (W=6)
REQ-039 XANDOR A=101010 B=010101 -> R=111111, CF=0, SF=1, ZF=0, out_valid 1 cycle after acceptance.
REQ-040 SHR A=101011 B=000001 -> R=010101, CF=1, SF=0, ZF=0, out_valid 2 cycles after acceptance.
REQ-041 SHL A=111111 B=000111 -> R=000000, CF=0, ZF=1, out_valid 8 cycles after acceptance, busy high throughout.
REQ-042 ADD A=111111 B=000001 -> R=000000, CF=1, ZF=1; SUB A=000001 B=000010 -> R=111111, CF=1, SF=1.
REQ-043 Hold out_ready=0 for 3 cycles in DONE -> R and flags stable, in_ready=0; raise out_ready -> IDLE next cycle, in_ready=1.
REQ-044 Assert rst_n=0 during SHR shamt=5 at cycle 2 -> outputs immediately at reset values, no out_valid; a new op after reset completes correctly.
